dmem_responder: RTL



---
 rtl/dmem_responder.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory slave for the core's load/store port.
// It accepts one request, waits LATENCY edges, then performs an RV32I
// byte/half/word access. The response is returned over a valid/ready handshake.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_func3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0] DEPTH_L = 30'(DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic            cap_we;
  logic [31:0]     cap_addr;
  logic [31:0]     cap_wdata;
  logic [2:0]      cap_func3;
  logic [31:0]     mem [DEPTH_WORDS];

  logic            bad_f3;
  logic            misalign;
  logic            out_of_range;
  logic            err;
  logic            access;
  logic [AW-1:0]   idx;
  logic [31:0]     word_rd;

  // Little-endian lane select followed by sign or zero extension.
  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] word,
                                           input logic [1:0] lane);
    logic [31:0]        sh;
    logic signed [7:0]  sb;
    logic signed [15:0] shw;
    logic [31:0]        r;
    sh  = word >> {lane, 3'b000};
    sb  = sh[7:0];
    shw = sh[15:0];
    case (f3)
      3'b000:  r = 32'(sb);
      3'b001:  r = 32'(shw);
      3'b010:  r = word;
      3'b100:  r = {24'h0, sh[7:0]};
      3'b101:  r = {16'h0, sh[15:0]};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Read-modify-write merge: only the addressed byte/half lanes take new data.
  function automatic logic [31:0] store_merge(input logic [2:0] f3, input logic [31:0] old,
                                              input logic [31:0] wd, input logic [1:0] lane);
    logic [31:0] mask;
    logic [31:0] data;
    case (f3)
      3'b000:  begin mask = 32'h0000_00FF; data = {24'h0, wd[7:0]};  end
      3'b001:  begin mask = 32'h0000_FFFF; data = {16'h0, wd[15:0]}; end
      default: begin mask = 32'hFFFF_FFFF; data = wd;                end
    endcase
    mask = mask << {lane, 3'b000};
    data = data << {lane, 3'b000};
    return (old & ~mask) | (data & mask);
  endfunction

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign access    = (state == WAIT) && (cnt == 4'd0);
  assign idx       = cap_addr[AW+1:2];
  assign word_rd   = mem[idx];

  // Error classification of the captured request.
  always_comb begin
    bad_f3       = cap_we ? !(cap_func3 inside {3'b000, 3'b001, 3'b010})
                          : !(cap_func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misalign     = ((cap_func3[1:0] == 2'b01) && cap_addr[0]) ||
                   ((cap_func3[1:0] == 2'b10) && (cap_addr[1:0] != 2'b00));
    out_of_range = (cap_addr[31:2] >= DEPTH_L);
    err          = bad_f3 | misalign | out_of_range;
  end

  // Request/latency/response state machine with registered response data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_func3 <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cap_we    <= req_we;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            cap_func3 <= req_func3;
            cnt       <= CNT_INIT;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rsp_err   <= err;
            rsp_rdata <= (err || cap_we) ? 32'h0 : load_ext(cap_func3, word_rd, cap_addr[1:0]);
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage write on the access edge; reset on the same edge suppresses it.
  always_ff @(posedge clk) begin
    if (!rst && access && cap_we && !err) begin
      mem[idx] <= store_merge(cap_func3, word_rd, cap_wdata, cap_addr[1:0]);
    end
  end

endmodule
